// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder built from one full-add cell and a carry
// flip-flop. Operands are processed LSB first over WIDTH cycles; the result
// is published on sum/cout together with a one-cycle done pulse.
//
// Ports:
//   clk    - sole clock, rising edge
//   rst    - asynchronous, active-high reset
//   start  - request an addition (accepted only when idle)
//   a, b   - WIDTH-bit addends, captured on acceptance
//   cin    - carry-in, captured on acceptance
//   sum    - registered WIDTH-bit result
//   cout   - registered carry-out
//   busy   - high during the WIDTH processing cycles
//   done   - one-cycle pulse when sum/cout have just been updated
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             fa_sum_c;
  logic             fa_carry_c;

  // Single full-add cell on the current LSBs and the stored carry
  always_comb begin
    fa_sum_c   = a_q[0] ^ b_q[0] ^ carry_q;
    fa_carry_c = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_carry_c;
        // Result bits enter at the MSB so after WIDTH shifts bit 0 is aligned
        res_d   = {fa_sum_c, res_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          sum_d   = {fa_sum_c, res_q[WIDTH-1:1]};
          cout_d  = fa_carry_c;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags are registered copies of the state being entered
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random checks of serial_adder at WIDTH=8 and
// WIDTH=3, sharing one clock and reset.
module tb_serial_adder;

  logic       clk;
  logic       rst;

  logic       start8, cin8, cout8, busy8, done8;
  logic [7:0] a8, b8, sum8;

  logic       start3, cin3, cout3, busy3, done3;
  logic [2:0] a3, b3, sum3;

  int vectors;
  int miscompares;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .sum   (sum8),
    .cout  (cout8),
    .busy  (busy8),
    .done  (done8)
  );

  serial_adder #(.WIDTH(3)) dut3 (
    .clk   (clk),
    .rst   (rst),
    .start (start3),
    .a     (a3),
    .b     (b3),
    .cin   (cin3),
    .sum   (sum3),
    .cout  (cout3),
    .busy  (busy3),
    .done  (done3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 operation; optionally disturbs inputs and re-pulses start mid-run
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                     input bit disturb,
                     output logic [7:0] s, output logic co,
                     output int busy_n, output int done_n, output int done_at);
    @(negedge clk);
    a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    busy_n = 0; done_n = 0; done_at = 0; s = 'x; co = 1'bx;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (busy8) busy_n++;
      if (done8) begin
        done_n++;
        done_at = k + 1;
        s  = sum8;
        co = cout8;
      end
      if (disturb && k == 2) begin
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
      end
      if (disturb && k == 3) start8 = 1'b0;
    end
  endtask

  // One operation on each DUT in parallel
  task automatic op_both(input logic [7:0] av8, input logic [7:0] bv8, input logic cv8,
                         input logic [2:0] av3, input logic [2:0] bv3, input logic cv3,
                         output logic [7:0] s8, output logic co8, output int dn8,
                         output logic [2:0] s3, output logic co3, output int dn3);
    @(negedge clk);
    a8 = av8; b8 = bv8; cin8 = cv8; start8 = 1'b1;
    a3 = av3; b3 = bv3; cin3 = cv3; start3 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0; start3 = 1'b0;
    dn8 = 0; dn3 = 0; s8 = 'x; co8 = 1'bx; s3 = 'x; co3 = 1'bx;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      if (done8) begin dn8++; s8 = sum8; co8 = cout8; end
      if (done3) begin dn3++; s3 = sum3; co3 = cout3; end
    end
  endtask

  initial begin
    logic [7:0] s;
    logic       co;
    int         bn, dn, dat;
    logic [7:0] s8r, ra8, rb8;
    logic       co8r, rc8;
    logic [2:0] s3r, ra3, rb3;
    logic       co3r, rc3;
    int         dn8r, dn3r;
    logic [7:0] held;
    int         dones, first, last, gap_bad, unstable;

    vectors = 0; miscompares = 0;
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_done8", 32'(done8), 32'd0);
    chk("rst_sum8",  32'({cout8, sum8}), 32'd0);
    chk("rst_sum3",  32'({cout3, sum3, busy3, done3}), 32'd0);
    rst = 1'b0;

    // 0x0F + 0x01: latency, busy width, result
    op8(8'h0F, 8'h01, 1'b0, 1'b0, s, co, bn, dn, dat);
    chk("basic_sum",  32'(s), 32'h10);
    chk("basic_cout", 32'(co), 32'd0);
    chk("basic_busy_cycles", 32'(bn), 32'd8);
    chk("basic_done_edge", 32'(dat), 32'd9);
    chk("basic_done_count", 32'(dn), 32'd1);

    // Overflow into carry-out
    op8(8'hFF, 8'h01, 1'b0, 1'b0, s, co, bn, dn, dat);
    chk("ovf_sum",  32'(s), 32'h00);
    chk("ovf_cout", 32'(co), 32'd1);

    // All-ones plus carry-in
    op8(8'hFF, 8'hFF, 1'b1, 1'b0, s, co, bn, dn, dat);
    chk("max_sum",  32'(s), 32'hFF);
    chk("max_cout", 32'(co), 32'd1);

    // Inputs changed and start re-pulsed during RUN: 0x35 + 0x4A + 1 = 0x80
    op8(8'h35, 8'h4A, 1'b1, 1'b1, s, co, bn, dn, dat);
    chk("ign_sum",  32'(s), 32'h80);
    chk("ign_cout", 32'(co), 32'd0);
    chk("ign_done_count", 32'(dn), 32'd1);
    chk("ign_busy_cycles", 32'(bn), 32'd8);
    chk("ign_done_edge", 32'(dat), 32'd9);
    chk("hold_idle_sum", 32'(sum8), 32'h80);

    // Start held high: 0x12 + 0x34 = 0x46 repeated every 10 cycles
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    held = 8'h80; dones = 0; first = 0; last = 0; gap_bad = 0; unstable = 0;
    for (int n = 1; n <= 32; n++) begin
      @(negedge clk);
      if (done8) begin
        dones++;
        if (first == 0) first = n;
        else if (n - last != 10) gap_bad++;
        last = n;
        held = sum8;
        chk("held_sum", 32'({cout8, sum8}), 32'h046);
      end else if (sum8 !== held) begin
        unstable++;
      end
    end
    start8 = 1'b0;
    repeat (12) @(negedge clk);
    chk("held_done_count", 32'(dones), 32'd3);
    chk("held_first_done", 32'(first), 32'd9);
    chk("held_gap_errors", 32'(gap_bad), 32'd0);
    chk("held_sum_unstable", 32'(unstable), 32'd0);

    // Reset during the fourth RUN cycle, then restart
    @(negedge clk);
    a8 = 8'h0F; b8 = 8'h0F; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", 32'(busy8), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy8), 32'd0);
    chk("async_rst_done", 32'(done8), 32'd0);
    chk("async_rst_sum",  32'({cout8, sum8}), 32'd0);
    a8 = 8'h55; b8 = 8'h22; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("start_in_rst_busy", 32'(busy8), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1 start8 = 1'b0;
    dn = 0; dat = 0; s = 'x; co = 1'bx;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8) begin dn++; dat = k + 1; s = sum8; co = cout8; end
    end
    chk("post_rst_sum", 32'({co, s}), 32'h077);
    chk("post_rst_done_count", 32'(dn), 32'd1);
    chk("post_rst_done_edge", 32'(dat), 32'd9);

    // Directed pairs on both widths
    op_both(8'h00, 8'h00, 1'b1, 3'h7, 3'h7, 1'b1, s8r, co8r, dn8r, s3r, co3r, dn3r);
    chk("cin_only8", 32'({co8r, s8r}), 32'h001);
    chk("max3",      32'({co3r, s3r}), 32'hF);
    op_both(8'h80, 8'h80, 1'b0, 3'h5, 3'h3, 1'b0, s8r, co8r, dn8r, s3r, co3r, dn3r);
    chk("msb8",  32'({co8r, s8r}), 32'h100);
    chk("wrap3", 32'({co3r, s3r}), 32'h8);

    // Random operations on both widths
    for (int i = 0; i < 1000; i++) begin
      ra8 = 8'($urandom_range(0, 255)); rb8 = 8'($urandom_range(0, 255));
      rc8 = 1'($urandom_range(0, 1));
      ra3 = 3'($urandom_range(0, 7));   rb3 = 3'($urandom_range(0, 7));
      rc3 = 1'($urandom_range(0, 1));
      op_both(ra8, rb8, rc8, ra3, rb3, rc3, s8r, co8r, dn8r, s3r, co3r, dn3r);
      chk("rnd8", 32'({co8r, s8r}), 32'(9'(ra8) + 9'(rb8) + 9'(rc8)));
      chk("rnd3", 32'({co3r, s3r}), 32'(4'(ra3) + 4'(rb3) + 4'(rc3)));
      chk("rnd_dones", 32'({dn8r[7:0], dn3r[7:0]}), 32'h0101);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
